uart_tx_arbiter: RTL

- Shares one uart_tx serializer between P_REQ_NUM byte-stream requesters using round-robin arbitration with packet lock.
- A grant holds until the requester's last byte, or until P_MAX_BURST bytes have been sent, then re-arbitrates.
- Sits between application sources (command responders, log/debug streams) and the single uart_tx instance; its downstream port connects directly to uart_tx's valid/ready/data.

---
 rtl/uart_arb_pkg.sv | 50 +++++
 rtl/uart_rr_pick.sv | 43 ++++
 rtl/uart_tx_arbiter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_arb_pkg.sv
// Shared definitions for the uart_tx arbiter slice.
//
// Contents:
//   arb_state_e      - arbiter FSM encoding (IDLE / XFER)
//   clog2()          - ceiling log2 usable in constant expressions
//   ptr_width()      - width of a requester index / round-robin pointer
//   burst_cnt_width()- width of the per-grant burst counter
//   stall_cnt_width()- width of the stall counter (UART_ARB_TIMEOUT_EN builds)
//   DEF_*            - default parameter values for the arbiter top
package uart_arb_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_e;

  localparam int DEF_REQ_NUM        = 4;
  localparam int DEF_DATA_WIDTH     = 8;
  localparam int DEF_MAX_BURST      = 16;
  localparam int DEF_TIMEOUT_CYCLES = 1_000_000;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((longint'(1) << w) < longint'(value)) w++;
    return w;
  endfunction

  // Index width for n requesters, never narrower than one bit.
  function automatic int ptr_width(input int n);
    int w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

  // A counter that must hold values 0..max_burst.
  function automatic int burst_cnt_width(input int max_burst);
    int w;
    w = clog2(max_burst + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // A counter that must hold values 0..timeout_cycles.
  function automatic int stall_cnt_width(input int timeout_cycles);
    int w;
    w = clog2(timeout_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker.
//
// Returns the first asserted request at or above ptr, wrapping modulo P_N.
// Has no state of its own; the owner keeps and advances the pointer.
//
// Ports:
//   req   in  P_N      request vector
//   ptr   in  P_PTR_W  search start index (must be < P_N)
//   grant out P_N      one-hot winner, 0 when no request
//   any   out 1        at least one request asserted
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int P_N     = DEF_REQ_NUM,
  parameter int P_PTR_W = ptr_width(DEF_REQ_NUM)
) (
  input  logic [P_N-1:0]     req,
  input  logic [P_PTR_W-1:0] ptr,
  output logic [P_N-1:0]     grant,
  output logic               any
);

  localparam logic [P_N-1:0] ONE = P_N'(1);

  logic [2*P_N-1:0] req_dbl;
  logic [2*P_N-1:0] gnt_dbl;
  logic [P_N-1:0]   req_rot;
  logic [P_N-1:0]   gnt_rot;

  // Rotate requests right by ptr so the search start sits at bit 0, isolate
  // the lowest set bit, then rotate the winner back left by ptr. Duplicating
  // the vector turns each rotate into a plain shift.
  always_comb begin
    req_dbl = {req, req} >> ptr;
    req_rot = req_dbl[P_N-1:0];
    gnt_rot = req_rot & (~req_rot + ONE);
    gnt_dbl = {gnt_rot, gnt_rot} << ptr;
    grant   = gnt_dbl[2*P_N-1:P_N];
  end

  assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx serializer among P_REQ_NUM
// byte-stream requesters, with packet lock and an optional burst cap.
//
// Handshake: a byte moves on any rising clock edge where valid and ready are
// both high. A source holds data/last stable while valid is high until it
// sees ready; ready may depend combinationally on valid and the grant, but
// valid never depends on ready.
//
// Ports:
//   i_clk        in  1                      system clock
//   i_rst_n      in  1                      asynchronous reset, active low
//   i_req_data   in  P_REQ_NUM*DATA_WIDTH   requester k drives slice k
//   i_req_valid  in  P_REQ_NUM              per-requester byte valid
//   i_req_last   in  P_REQ_NUM              final byte of a packet (with valid)
//   o_req_ready  out P_REQ_NUM              per-requester ready
//   o_tx_data    out DATA_WIDTH             to uart_tx i_user_tx_data
//   o_tx_valid   out 1                      to uart_tx i_user_tx_valid
//   i_tx_ready   in  1                      from uart_tx o_user_tx_ready
//   o_grant      out P_REQ_NUM              one-hot owner, 0 when idle
//   o_busy       out 1                      high while a grant is held
//   o_timeout    out 1                      pulse on a forced (stall) release
//
// Build option: define UART_ARB_TIMEOUT_EN to release a grant whose owner has
// stalled (valid low) for P_TIMEOUT_CYCLES cycles. Without it o_timeout is
// tied low and a stalled owner keeps the grant indefinitely.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int P_REQ_NUM         = DEF_REQ_NUM,
  parameter int P_UART_DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int P_MAX_BURST       = DEF_MAX_BURST,
  parameter int P_TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                                   i_clk,
  input  logic                                   i_rst_n,
  input  logic [P_REQ_NUM*P_UART_DATA_WIDTH-1:0] i_req_data,
  input  logic [P_REQ_NUM-1:0]                   i_req_valid,
  input  logic [P_REQ_NUM-1:0]                   i_req_last,
  output logic [P_REQ_NUM-1:0]                   o_req_ready,
  output logic [P_UART_DATA_WIDTH-1:0]           o_tx_data,
  output logic                                   o_tx_valid,
  input  logic                                   i_tx_ready,
  output logic [P_REQ_NUM-1:0]                   o_grant,
  output logic                                   o_busy,
  output logic                                   o_timeout
);

  localparam int W       = P_UART_DATA_WIDTH;
  localparam int PTR_W   = ptr_width(P_REQ_NUM);
  localparam int BURST_W = burst_cnt_width(P_MAX_BURST);

  localparam logic [PTR_W-1:0]   PTR_MAX    = PTR_W'(P_REQ_NUM - 1);
  // Count value seen on the beat that fills the burst (count is pre-increment).
  localparam logic [BURST_W-1:0] BURST_LAST =
    BURST_W'((P_MAX_BURST > 0) ? P_MAX_BURST - 1 : 0);

  arb_state_e             state;
  arb_state_e             state_d;
  logic [P_REQ_NUM-1:0]   grant_q;
  logic [PTR_W-1:0]       gidx_q;
  logic [PTR_W-1:0]       ptr_q;
  logic [BURST_W-1:0]     burst_q;

  logic [P_REQ_NUM-1:0]   pick_grant;
  logic                   pick_any;
  logic [PTR_W-1:0]       pick_idx;

  logic                   sel_valid;
  logic                   sel_last;
  logic [W-1:0]           sel_data;
  logic                   beat;
  logic                   last_hit;
  logic                   burst_hit;
  logic                   timeout_hit;
  logic                   release_hit;

  uart_rr_pick #(
    .P_N     (P_REQ_NUM),
    .P_PTR_W (PTR_W)
  ) u_pick (
    .req   (i_req_valid),
    .ptr   (ptr_q),
    .grant (pick_grant),
    .any   (pick_any)
  );

  // Index of the picker's winner, stored alongside the one-hot grant so the
  // pointer can be advanced without re-encoding later.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      if (pick_grant[i]) pick_idx = PTR_W'(i);
    end
  end

  // Owner's lane, selected with the one-hot grant (all zero when idle).
  always_comb begin
    sel_data = '0;
    for (int i = 0; i < P_REQ_NUM; i++) begin
      if (grant_q[i]) sel_data = sel_data | i_req_data[i*W +: W];
    end
  end

  assign sel_valid = |(i_req_valid & grant_q);
  assign sel_last  = |(i_req_last & grant_q);

  assign beat      = (state == ST_XFER) && sel_valid && i_tx_ready;
  assign last_hit  = beat && sel_last;
  assign burst_hit = (P_MAX_BURST > 0) && beat && (burst_q == BURST_LAST);

  // A last byte that also fills the burst is still a single release.
  assign release_hit = last_hit || burst_hit || timeout_hit;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL_W = stall_cnt_width(P_TIMEOUT_CYCLES);
  // Count value during the stall cycle that reaches the limit.
  localparam logic [STALL_W-1:0] STALL_LAST =
    STALL_W'((P_TIMEOUT_CYCLES > 0) ? P_TIMEOUT_CYCLES - 1 : 0);

  logic [STALL_W-1:0] stall_q;

  // Held at zero while idle so every grant starts from a clean count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_q <= '0;
    end else if ((state == ST_IDLE) || beat) begin
      stall_q <= '0;
    end else if (!sel_valid) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_XFER) && !sel_valid && (stall_q == STALL_LAST);
  assign o_timeout   = timeout_hit;
`else
  assign timeout_hit = 1'b0;
  assign o_timeout   = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // FSM: next state. IDLE always lasts at least one cycle because the grant
  // is registered on the IDLE->XFER edge.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE: if (pick_any)    state_d = ST_XFER;
      ST_XFER: if (release_hit) state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // FSM: outputs. XFER is a pure combinational pass-through of the owner's
  // lane; nothing is buffered, so uart_tx sees at most one byte in flight.
  // ---------------------------------------------------------------------
  always_comb begin
    o_req_ready = '0;
    o_tx_valid  = 1'b0;
    o_tx_data   = '0;
    if (state == ST_XFER) begin
      o_req_ready = grant_q & {P_REQ_NUM{i_tx_ready}};
      o_tx_valid  = sel_valid;
      o_tx_data   = sel_data;
    end
  end

  assign o_grant = grant_q;
  assign o_busy  = (state == ST_XFER);

  // ---------------------------------------------------------------------
  // Grant, pointer and burst bookkeeping
  // ---------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= '0;
      burst_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            grant_q <= pick_grant;
            gidx_q  <= pick_idx;
            burst_q <= '0;
          end
        end
        ST_XFER: begin
          if (release_hit) begin
            grant_q <= '0;
            ptr_q   <= (gidx_q == PTR_MAX) ? '0 : gidx_q + 1'b1;
            burst_q <= '0;
          end else if (beat) begin
            burst_q <= burst_q + 1'b1;
          end
        end
        default: begin
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
